// File: rtl/zorro_master_cycle.sv
// zorro_master_cycle: runs one Zorro III-style bus cycle per internal request.
// It drives the address and strobes, waits for DTACK/BERR (with timeout) and reports back.
module zorro_master_cycle #(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter int unsigned CNT_W          = 16
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        bus_owned,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_read,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_be,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        busy,
    output logic [31:0] ADDR_OUT,
    output logic        ADDR_OE,
    output logic        READ,
    output logic        FCS_n,
    output logic [3:0]  DS_n,
    output logic        DOE,
    output logic [31:0] DATA_OUT,
    input  logic [31:0] DATA_IN,
    input  logic        DTACK_n,
    input  logic        BERR_n
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_ASSERT,
        S_STROBE,
        S_RELEASE,
        S_DONE
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;
    logic [31:0]      addr_q, addr_d;
    logic             read_q, read_d;
    logic [31:0]      wdata_q, wdata_d;
    logic [3:0]       be_q, be_d;
    logic [31:0]      rdata_q, rdata_d;
    logic [1:0]       dtk_sync_q;
    logic [1:0]       berr_sync_q;
    logic             dtk;
    logic             berr;

    assign dtk       = ~dtk_sync_q[1];
    assign berr      = ~berr_sync_q[1];
    assign ADDR_OUT  = addr_q;
    assign READ      = read_q;
    assign DATA_OUT  = wdata_q;
    assign rsp_rdata = rdata_q;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            err_q       <= 1'b0;
            addr_q      <= '0;
            read_q      <= 1'b1;
            wdata_q     <= '0;
            be_q        <= '0;
            rdata_q     <= '0;
            dtk_sync_q  <= 2'b11;
            berr_sync_q <= 2'b11;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            err_q       <= err_d;
            addr_q      <= addr_d;
            read_q      <= read_d;
            wdata_q     <= wdata_d;
            be_q        <= be_d;
            rdata_q     <= rdata_d;
            dtk_sync_q  <= {dtk_sync_q[0], DTACK_n};
            berr_sync_q <= {berr_sync_q[0], BERR_n};
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        err_d     = err_q;
        addr_d    = addr_q;
        read_d    = read_q;
        wdata_d   = wdata_q;
        be_d      = be_q;
        rdata_d   = rdata_q;
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        rsp_err   = 1'b0;
        busy      = 1'b1;
        ADDR_OE   = 1'b0;
        FCS_n     = 1'b1;
        DS_n      = 4'hF;
        DOE       = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                busy      = 1'b0;
                req_ready = bus_owned & ~RESET;
                if (req_valid && req_ready) begin
                    addr_d  = req_addr;
                    read_d  = req_read;
                    wdata_d = req_wdata;
                    be_d    = req_be;
                    err_d   = 1'b0;
                    state_d = S_ADDR;
                end
            end
            S_ADDR: begin
                ADDR_OE = 1'b1;
                state_d = S_ASSERT;
            end
            S_ASSERT: begin
                ADDR_OE = 1'b1;
                FCS_n   = 1'b0;
                DOE     = ~read_q;
                cnt_d   = '0;
                state_d = S_STROBE;
            end
            S_STROBE: begin
                ADDR_OE = 1'b1;
                FCS_n   = 1'b0;
                DS_n    = ~be_q;
                DOE     = 1'b1;
                cnt_d   = cnt_q + CNT_W'(1);
                // BERR wins over a simultaneous DTACK
                if (berr) begin
                    err_d   = 1'b1;
                    cnt_d   = '0;
                    state_d = S_RELEASE;
                end else if (dtk) begin
                    if (read_q) rdata_d = DATA_IN;
                    cnt_d   = '0;
                    state_d = S_RELEASE;
                end else if (cnt_q == CNT_LAST) begin
                    err_d   = 1'b1;
                    cnt_d   = '0;
                    state_d = S_RELEASE;
                end
            end
            S_RELEASE: begin
                ADDR_OE = 1'b1;
                cnt_d   = cnt_q + CNT_W'(1);
                if (!dtk && !berr) begin
                    state_d = S_DONE;
                end else if (cnt_q == CNT_LAST) begin
                    err_d   = 1'b1;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                rsp_valid = 1'b1;
                rsp_err   = err_q;
                err_d     = 1'b0;
                state_d   = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_zorro_master_cycle.sv
// tb_zorro_master_cycle: scenario tasks with a behavioural responder
// and a response scoreboard for zorro_master_cycle.
module tb_zorro_master_cycle;

    logic        CLK = 1'b0;
    logic        RESET = 1'b1;
    logic        bus_owned = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_read = 1'b0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic [3:0]  req_be = '0;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        busy;
    logic [31:0] ADDR_OUT;
    logic        ADDR_OE;
    logic        READ;
    logic        FCS_n;
    logic [3:0]  DS_n;
    logic        DOE;
    logic [31:0] DATA_OUT;
    logic [31:0] DATA_IN = '0;
    logic        DTACK_n = 1'b1;
    logic        BERR_n = 1'b1;

    int checks = 0;
    int errors = 0;
    logic [32:0] exp_q[$];
    logic [31:0] last_rd = '0;

    // responder configuration
    bit respond = 1'b0;
    bit use_berr = 1'b0;
    bit hold_forever = 1'b0;
    int dly = 3;
    int stall = 0;
    int fcs_cnt = 0;
    int rel_cnt = 0;

    // per-cycle observations from run_cycle
    int          r_fcs_low;
    int          r_rel;
    logic [3:0]  r_ds;
    logic        r_rd;
    logic        r_doe;
    logic [31:0] r_dout;
    logic        r_fcs_pre;
    bit          r_ok;

    zorro_master_cycle #(.TIMEOUT_CYCLES(16), .CNT_W(16)) dut (
        .CLK(CLK), .RESET(RESET), .bus_owned(bus_owned),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_read(req_read), .req_addr(req_addr),
        .req_wdata(req_wdata), .req_be(req_be),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err), .busy(busy),
        .ADDR_OUT(ADDR_OUT), .ADDR_OE(ADDR_OE), .READ(READ),
        .FCS_n(FCS_n), .DS_n(DS_n), .DOE(DOE),
        .DATA_OUT(DATA_OUT), .DATA_IN(DATA_IN),
        .DTACK_n(DTACK_n), .BERR_n(BERR_n)
    );

    always #5 CLK = ~CLK;

    initial begin
        #2000000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // responder: acknowledge dly cycles after FCS_n low, release stall cycles after FCS_n high
    always @(posedge CLK) begin
        if (!FCS_n) begin
            fcs_cnt <= fcs_cnt + 1;
            rel_cnt <= 0;
            if (respond && (fcs_cnt + 1 == dly)) begin
                DTACK_n <= 1'b0;
                if (use_berr) BERR_n <= 1'b0;
            end
        end else begin
            fcs_cnt <= 0;
            if (!hold_forever && (!DTACK_n || !BERR_n)) begin
                rel_cnt <= rel_cnt + 1;
                if (rel_cnt + 1 > stall) begin
                    DTACK_n <= 1'b1;
                    BERR_n  <= 1'b1;
                end
            end
        end
    end

    // scoreboard: every rsp_valid must match the oldest expectation
    always @(negedge CLK) begin
        logic [32:0] e;
        if (rsp_valid) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_rsp err=%b rdata=%h required no response",
                         rsp_err, rsp_rdata);
            end else begin
                e = exp_q.pop_front();
                if ({rsp_err, rsp_rdata} !== e) begin
                    errors++;
                    $display("FAIL rsp err=%b rdata=%h required err=%b rdata=%h",
                             rsp_err, rsp_rdata, e[32], e[31:0]);
                end
            end
        end
    end

    task automatic run_cycle(input logic rd, input logic [31:0] a,
                             input logic [31:0] wd, input logic [3:0] be,
                             input logic exp_err, input logic [31:0] exp_rd);
        int n;
        r_fcs_low = 0; r_rel = 0; r_ds = 4'hF; r_rd = 1'b0;
        r_doe = 1'b0; r_dout = '0; r_fcs_pre = 1'b0; r_ok = 1'b0;
        @(negedge CLK);
        n = 0;
        while (!req_ready && n < 50) begin
            @(negedge CLK);
            n++;
        end
        checks++;
        if (req_ready !== 1'b1) begin
            errors++;
            $display("FAIL accept req_ready=%b required 1", req_ready);
            return;
        end
        req_read = rd; req_addr = a; req_wdata = wd; req_be = be;
        req_valid = 1'b1;
        exp_q.push_back({exp_err, exp_rd});
        @(posedge CLK);
        #1 req_valid = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(negedge CLK);
            if (rsp_valid) begin
                r_ok = 1'b1;
                break;
            end
            r_fcs_pre = FCS_n;
            if (!FCS_n) begin
                if (r_fcs_low > 0) begin
                    r_ds = DS_n; r_rd = READ; r_doe = DOE; r_dout = DATA_OUT;
                end
                r_fcs_low++;
            end else if (ADDR_OE && r_fcs_low > 0) begin
                r_rel++;
            end
        end
        checks++;
        if (!r_ok) begin
            errors++;
            $display("FAIL completion rsp_valid=0 after 400 cycles required 1");
            exp_q.delete();
            return;
        end
        @(negedge CLK);
        checks++;
        if (rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL rsp_pulse rsp_valid=%b required 0", rsp_valid);
        end
    endtask

    task automatic test_reset();
        RESET = 1'b1; bus_owned = 1'b1; req_valid = 1'b0;
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        checks++;
        if ({req_ready, rsp_valid, rsp_err, busy, ADDR_OE, FCS_n, DS_n, DOE, READ}
            !== {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'hF, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL reset_ctl rdy=%b rv=%b re=%b busy=%b aoe=%b fcs=%b ds=%h doe=%b rd=%b",
                     req_ready, rsp_valid, rsp_err, busy, ADDR_OE, FCS_n, DS_n, DOE, READ);
        end
        checks++;
        if ({ADDR_OUT, DATA_OUT, rsp_rdata} !== 96'd0) begin
            errors++;
            $display("FAIL reset_data addr=%h dout=%h rdata=%h required 0",
                     ADDR_OUT, DATA_OUT, rsp_rdata);
        end
        RESET = 1'b0;
        last_rd = '0;
    endtask

    task automatic test_read();
        respond = 1'b1; use_berr = 1'b0; dly = 3; stall = 0;
        DATA_IN = 32'hDEADBEEF;
        run_cycle(1'b1, 32'h0001_2344, 32'h0, 4'hF, 1'b0, 32'hDEADBEEF);
        last_rd = 32'hDEADBEEF;
        checks++;
        if ({r_rd, r_ds} !== {1'b1, 4'h0}) begin
            errors++;
            $display("FAIL read_strobe READ=%b DS_n=%h required 1 0", r_rd, r_ds);
        end
        checks++;
        if (r_fcs_pre !== 1'b1) begin
            errors++;
            $display("FAIL read_fcs_release FCS_n=%b required 1", r_fcs_pre);
        end
        checks++;
        if (r_fcs_low - 1 < 3 || r_fcs_low - 1 > 6) begin
            errors++;
            $display("FAIL read_strobe_len got %0d required 3..6", r_fcs_low - 1);
        end
    endtask

    task automatic test_write();
        respond = 1'b1; dly = 2; stall = 0;
        DATA_IN = 32'h5555_5555;
        run_cycle(1'b0, 32'h00E8_0040, 32'h1234_5678, 4'b0011, 1'b0, last_rd);
        checks++;
        if ({r_rd, r_ds, r_doe, r_dout} !== {1'b0, 4'b1100, 1'b1, 32'h1234_5678}) begin
            errors++;
            $display("FAIL write_strobe READ=%b DS_n=%b DOE=%b DATA_OUT=%h required 0 1100 1 12345678",
                     r_rd, r_ds, r_doe, r_dout);
        end
    endtask

    task automatic test_timeout();
        respond = 1'b0;
        DATA_IN = 32'hAAAA_5555;
        run_cycle(1'b1, 32'h00FF_0000, 32'h0, 4'hF, 1'b1, last_rd);
        checks++;
        if (r_fcs_low - 1 != 16) begin
            errors++;
            $display("FAIL timeout_strobe_len got %0d required 16", r_fcs_low - 1);
        end
        checks++;
        if ({r_fcs_pre, r_rel} !== {1'b1, 32'd1}) begin
            errors++;
            $display("FAIL timeout_release FCS_n=%b rel=%0d required 1 1", r_fcs_pre, r_rel);
        end
    endtask

    task automatic test_berr_dtack();
        respond = 1'b1; use_berr = 1'b1; dly = 2; stall = 0;
        DATA_IN = 32'hCAFE_F00D;
        run_cycle(1'b1, 32'h0000_1000, 32'h0, 4'hF, 1'b1, last_rd);
        use_berr = 1'b0;
        checks++;
        if (rsp_rdata !== last_rd) begin
            errors++;
            $display("FAIL berr_rdata got %h required %h", rsp_rdata, last_rd);
        end
    endtask

    task automatic test_release_stall();
        respond = 1'b1; dly = 2; stall = 5;
        DATA_IN = 32'h0BAD_F00D;
        run_cycle(1'b1, 32'h0000_2000, 32'h0, 4'hF, 1'b0, 32'h0BAD_F00D);
        last_rd = 32'h0BAD_F00D;
        checks++;
        if (r_rel < 7 || r_rel > 15) begin
            errors++;
            $display("FAIL stall_release_len got %0d required 7..15", r_rel);
        end
        stall = 0;
    endtask

    task automatic test_release_timeout();
        respond = 1'b1; dly = 2; stall = 0; hold_forever = 1'b1;
        run_cycle(1'b0, 32'h0000_3000, 32'h0F0F_0F0F, 4'hF, 1'b1, last_rd);
        checks++;
        if (r_rel != 16) begin
            errors++;
            $display("FAIL release_timeout_len got %0d required 16", r_rel);
        end
        hold_forever = 1'b0;
        repeat (6) @(negedge CLK);
    endtask

    task automatic test_bus_owned();
        @(negedge CLK);
        bus_owned = 1'b0;
        req_read = 1'b1; req_addr = 32'h0000_4000; req_be = 4'hF;
        req_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge CLK);
            checks++;
            if ({req_ready, busy, FCS_n, ADDR_OE} !== 4'b0010) begin
                errors++;
                $display("FAIL not_owned rdy=%b busy=%b FCS_n=%b ADDR_OE=%b required 0 0 1 0",
                         req_ready, busy, FCS_n, ADDR_OE);
            end
        end
        req_valid = 1'b0;
        bus_owned = 1'b1;
    endtask

    task automatic test_reset_mid();
        int n;
        respond = 1'b0;
        @(negedge CLK);
        req_read = 1'b1; req_addr = 32'h0000_5000; req_be = 4'hF;
        req_valid = 1'b1;
        @(posedge CLK);
        #1 req_valid = 1'b0;
        n = 0;
        while (DS_n !== 4'h0 && n < 20) begin
            @(negedge CLK);
            n++;
        end
        checks++;
        if (DS_n !== 4'h0) begin
            errors++;
            $display("FAIL mid_reach_strobe DS_n=%h required 0", DS_n);
        end
        repeat (3) @(negedge CLK);
        RESET = 1'b1;
        @(negedge CLK);
        checks++;
        if ({FCS_n, DS_n, ADDR_OE, busy, rsp_valid, rsp_rdata} !== {1'b1, 4'hF, 1'b0, 1'b0, 1'b0, 32'h0}) begin
            errors++;
            $display("FAIL mid_reset FCS_n=%b DS_n=%h ADDR_OE=%b busy=%b rv=%b rdata=%h required 1 F 0 0 0 0",
                     FCS_n, DS_n, ADDR_OE, busy, rsp_valid, rsp_rdata);
        end
        RESET = 1'b0;
        last_rd = '0;
        repeat (30) @(negedge CLK);
    endtask

    task automatic test_back_to_back();
        respond = 1'b1; dly = 1; stall = 0;
        DATA_IN = 32'h1357_9BDF;
        run_cycle(1'b1, 32'h0000_0100, 32'h0, 4'hF, 1'b0, 32'h1357_9BDF);
        last_rd = 32'h1357_9BDF;
        DATA_IN = 32'h2468_ACE0;
        run_cycle(1'b0, 32'h0000_0104, 32'hA5A5_5A5A, 4'b0000, 1'b0, last_rd);
        checks++;
        if (r_ds !== 4'hF || r_dout !== 32'hA5A5_5A5A) begin
            errors++;
            $display("FAIL be_zero DS_n=%h DATA_OUT=%h required F a5a55a5a", r_ds, r_dout);
        end
    endtask

    initial begin
        test_reset();
        test_read();
        test_write();
        test_timeout();
        test_berr_dtack();
        test_release_stall();
        test_release_timeout();
        test_bus_owned();
        test_reset_mid();
        test_back_to_back();
        repeat (5) @(negedge CLK);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain left=%0d required 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/zorro_master_cycle.md
Name: zorro_master_cycle

Overview:
- Bus-initiator sequencer: turns one internal read/write request into a single Zorro III-style bus cycle.
- Drives address, FCS_n, READ and DS_n, then waits for DTACK_n or BERR_n from the addressed responder.
- Returns read data or an error status to the internal requester (DMA engine, flash programming logic).
- Sits between internal requesters and the board's bus buffers; active only while the arbiter reports bus ownership.

Parameters:
TIMEOUT_CYCLES, 255, CLK cycles in STROBE or RELEASE without the expected response before the cycle aborts with error; valid range 4..65535.
CNT_W, 16, width of the timeout counter; must satisfy 2^CNT_W > TIMEOUT_CYCLES.

Ports:
CLK  in  1  single system clock; all logic on rising edge
RESET  in  1  synchronous, active-high reset
bus_owned  in  1  arbiter grant; bus mastership held
req_valid  in  1  request present
req_ready  out  1  request accepted this cycle when high with req_valid
req_read  in  1  1=read, 0=write
req_addr  in  32  byte address
req_wdata  in  32  write data
req_be  in  4  byte enables, bit3=D31..24
rsp_valid  out  1  one-cycle completion pulse
rsp_rdata  out  32  captured read data; valid with rsp_valid
rsp_err  out  1  1=BERR or timeout; valid with rsp_valid
busy  out  1  high in every state except IDLE
ADDR_OUT  out  32  bus address
ADDR_OE  out  1  address buffer enable
READ  out  1  bus direction
FCS_n  out  1  full-cycle strobe, active low
DS_n  out  4  data strobes, active low
DOE  out  1  data buffer enable
DATA_OUT  out  32  write data to bus
DATA_IN  in  32  read data from bus
DTACK_n  in  1  responder acknowledge; asynchronous
BERR_n  in  1  bus error; asynchronous

Behaviour:
- Reset outputs:
  - req_ready=0, rsp_valid=0, rsp_err=0, rsp_rdata=0, busy=0.
  - ADDR_OE=0, FCS_n=1, DS_n=4'hF, DOE=0, READ=1, ADDR_OUT=0, DATA_OUT=0.
  - State IDLE, counter=0, synchronizers loaded with 1.
- Reset mid-cycle: on the next edge, all outputs return to reset values and no rsp_valid pulse is issued.
- Input synchronisation: DTACK_n and BERR_n each pass through a 2-flop synchronizer. The FSM uses only the synchronized versions, named dtk and berr, both active high after inversion.
- IDLE:
  - req_ready = bus_owned.
  - On req_valid & req_ready, latch addr, read, wdata, be, then go to ADDR.
  - req_ready is low in all other states.
- ADDR (1 cycle):
  - ADDR_OE=1; ADDR_OUT and READ are driven from the latched values.
  - FCS_n=1, DS_n=F.
  - Next state: ASSERT.
- ASSERT (1 cycle):
  - FCS_n=0.
  - DATA_OUT = latched wdata; DOE=1 for writes.
  - Next state: STROBE; counter cleared.
- STROBE:
  - DS_n = ~be; DOE=1; counter increments by 1 each cycle.
  - berr: set err flag, go to RELEASE. berr has priority when berr and dtk are seen together.
  - Else dtk: capture DATA_IN into rsp_rdata if read (unchanged on writes), go to RELEASE.
  - Else counter reaches TIMEOUT_CYCLES-1: set err flag, go to RELEASE.
- RELEASE:
  - FCS_n=1, DS_n=F, DOE=0; ADDR_OE stays 1; counter cleared on entry.
  - Exit when dtk=0 and berr=0, or when the counter reaches TIMEOUT_CYCLES-1. A release timeout forces err.
  - Next state: DONE.
- DONE (1 cycle):
  - ADDR_OE=0; rsp_valid=1; rsp_err = err flag.
  - Next state: IDLE; err flag cleared.
- Ownership: bus_owned is checked only at accept; loss of bus_owned mid-cycle does not abort the cycle.
- Minimum latency: request accept to rsp_valid is 6 cycles with DTACK_n already low at ASSERT. Breakdown: ADDR, ASSERT, STROBE ≥1, RELEASE ≥1, DONE, with the 2-cycle synchronizer delay adding to STROBE/RELEASE dwell.
- rsp_rdata holds its value until the next read completes.
- req_be=0 is legal: DS_n stays F and the cycle still runs to DTACK or timeout.

Test Plan:
- Read, responder asserting DTACK_n 3 cycles after FCS_n low:
  - Stimulus: addr 0x00012344, DATA_IN 0xDEADBEEF.
  - Required: READ=1, DS_n=0 during STROBE; rsp_valid once with rsp_rdata=0xDEADBEEF, rsp_err=0; FCS_n high before rsp_valid.
- Write, addr 0x00E80040, wdata 0x12345678, be 4'b0011:
  - Required: DS_n=4'b1100, DATA_OUT=0x12345678, DOE=1 in STROBE; rsp_err=0; rsp_rdata unchanged from prior read.
- No responder, TIMEOUT_CYCLES=16:
  - Required: STROBE lasts exactly 16 cycles; rsp_valid with rsp_err=1; FCS_n back to 1.
- BERR_n and DTACK_n fall on the same edge:
  - Required: rsp_err=1; rsp_rdata not updated.
- Responder holds DTACK_n low after FCS_n rises (release stall):
  - Stall of 5 cycles: rsp_valid only after the synchronized release, with rsp_err=0.
  - Stall held forever with TIMEOUT_CYCLES=16: rsp_err=1 after 16 RELEASE cycles.
- bus_owned toggling and RESET mid-cycle:
  - bus_owned=0 with req_valid=1: req_ready=0 and no bus activity.
  - RESET asserted during STROBE: next edge gives FCS_n=1, DS_n=F, ADDR_OE=0, and no rsp_valid.
  - After release, a new request accepts normally.
